gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Parametrised successor to the bimodal branch predictor between Fetcher and ReorderBuffer.
- Holds a table of saturating counters, indexed by PC XOR a speculative global history register (GHR).
- Predicts combinationally for the fetched instruction and updates at commit.
- Restores the GHR from a ROB-carried snapshot on misprediction.

Parameters:
- INDEX_BITS, 9: log2 of counter-table depth.
- GHR_BITS, 8: global history length; legal range 1..INDEX_BITS.
- CNT_BITS, 2: counter width; legal range 2..4.
- USE_GSHARE, 1: 1 = gshare indexing; 0 = bimodal indexing with the GHR still maintained.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  global stall; state frozen when low
- fetch_valid_in  input  1  fetcher accepts inst_from_fetcher this cycle
- pc_from_fetcher  input  32  fetched instruction address
- inst_from_fetcher  input  32  fetched instruction
- imm_to_fetcher  output  32  sign-extended JAL or branch offset
- jump_predict_flag_to_fetcher  output  1  predicted taken
- is_jalr_inst_to_fetcher  output  1  opcode is JALR
- ghr_to_fetcher  output  GHR_BITS  GHR before this instruction's shift; travels with the instruction to the ROB
- enable_from_reorderbuffer  input  1  committing a conditional branch
- inst_addr_from_reorderbuffer  input  32  committed branch PC
- jump_result_from_reorderbuffer  input  1  actual outcome
- ghr_from_reorderbuffer  input  GHR_BITS  snapshot carried with the branch
- mispredict_from_reorderbuffer  input  1  prediction was wrong; pipeline flush this cycle

Behaviour:
- Clock and reset:
  - One clock, clk_in.
  - Reset is synchronous and active-high on rst_in.
  - Reset sets every counter to weakly-not-taken, 2^(CNT_BITS-1)-1, and sets the GHR to 0.
  - Reset overrides rdy_in and all other inputs.
- Index function:
  - idx(pc, h) = pc[INDEX_BITS+1:2] XOR zero-extended h when USE_GSHARE=1.
  - idx(pc, h) = pc[INDEX_BITS+1:2] when USE_GSHARE=0.
- Prediction (purely combinational, zero latency):
  - JAL: taken, imm = J-immediate.
  - BRANCH: MSB of counter[idx(pc_from_fetcher, GHR)], imm = B-immediate.
  - Any other opcode: not taken, imm = B-immediate pattern.
  - is_jalr_inst_to_fetcher = (opcode == JALR).
  - ghr_to_fetcher = current GHR.
  - Outputs remain valid while rdy_in is low.
- Speculative GHR update:
  - Condition: rdy_in & fetch_valid_in & opcode BRANCH & !(enable_from_reorderbuffer & mispredict_from_reorderbuffer).
  - Action: GHR <= {GHR[GHR_BITS-2:0], predicted taken}. When GHR_BITS = 1, GHR <= predicted taken.
  - JAL and JALR do not shift the GHR.
- Commit update, when rdy_in & enable_from_reorderbuffer:
  - j = idx(inst_addr_from_reorderbuffer, ghr_from_reorderbuffer).
  - Taken: counter[j] increments, saturating at 2^CNT_BITS-1.
  - Not taken: counter[j] decrements, saturating at 0.
  - If mispredict_from_reorderbuffer is also set: GHR <= {ghr_from_reorderbuffer[GHR_BITS-2:0], jump_result_from_reorderbuffer}. This overrides any same-cycle fetch shift.
- Simultaneous events:
  - Same-cycle fetch read and commit write of the same entry: the fetch sees the old value (no bypass). The new value is visible next cycle.
  - mispredict_from_reorderbuffer without enable_from_reorderbuffer is ignored.
- Reset asserted mid-stream discards all pending history. The ROB is responsible for its own flush.

Optional Feature:
- Macro: GSHARE_PREDICTOR_STATS_EN.
- Defined: adds two outputs:
  - stat_branch_cnt_out, 32 bits: increments on each commit update.
  - stat_mispredict_cnt_out, 32 bits: increments on each commit with mispredict set.
  - Both reset to 0, wrap modulo 2^32, and freeze when rdy_in is low.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared constants header (existing constants.v): OPCODE_RANGE, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH, ADDR_TYPE, INST_TYPE, DATA_TYPE, TRUE, FALSE.
- Add PREDICTOR_INDEX_BITS and PREDICTOR_GHR_BITS as system-wide defaults for the parameters.
- One sub-module: sat_counter_update. It is combinational next-value logic for a CNT_BITS counter: input value and direction, output the saturated result. The table itself stays in the parent.

Test Plan:
- Reset, then fetch BRANCH at pc 0x100 with GHR 0 -> jump_predict_flag_to_fetcher = 0, ghr_to_fetcher = 0.
- Two taken commits at pc 0x100 with ghr_from_reorderbuffer = 0, then fetch 0x100 with GHR 0 -> predicted taken. After 5 taken commits and 1 not-taken commit -> counter = 2, still taken.
- Fetch three BRANCHes predicted 0,0,0, then commit with mispredict, ghr_from_reorderbuffer = 8'h05, result 1 -> next-cycle GHR = 8'h0B.
- Same cycle: fetch BRANCH plus commit mispredict with snapshot 8'h00, result 0 -> GHR = 8'h00 (fetch shift dropped).
- Fetch JAL with offset -4 -> taken, imm_to_fetcher = 32'hFFFFFFFC, GHR unchanged. Fetch JALR -> is_jalr_inst_to_fetcher = 1.
- rdy_in = 0 during a commit -> counters, GHR and stats unchanged. With GSHARE_PREDICTOR_STATS_EN: 3 commits, 1 mispredict -> stat_branch_cnt_out = 3, stat_mispredict_cnt_out = 1.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// Shared constants for the gshare predictor: opcode field, opcodes, bus types and system-wide sizing defaults.
// Compile-time only: no logic, no latency.
// No flow control; consumers import these names.
package gshare_predictor_pkg;

  localparam int OPCODE_RANGE_HI = 6;
  localparam int OPCODE_RANGE_LO = 0;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] data_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int PREDICTOR_INDEX_BITS = 9;
  localparam int PREDICTOR_GHR_BITS   = 8;

endpackage

// File: rtl/sat_counter_update.sv
// Next-value logic for a CNT_BITS saturating counter; increments or decrements, clamping at the ends.
// Purely combinational, zero latency.
// No flow control; the caller decides when to write the result back.
module sat_counter_update #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] i_val,
  input  logic                i_inc,
  output logic [CNT_BITS-1:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_inc) begin
      if (i_val != {CNT_BITS{1'b1}}) o_val = i_val + CNT_BITS'(1);
    end else begin
      if (i_val != {CNT_BITS{1'b0}}) o_val = i_val - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: counter table indexed by PC^GHR, speculative GHR, commit-time training and GHR repair.
// Prediction is combinational (zero latency); table/GHR writes land on the next clk_in edge.
// rdy_in low freezes all state; GSHARE_PREDICTOR_STATS_EN adds commit/mispredict counters.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int INDEX_BITS = PREDICTOR_INDEX_BITS,
  parameter int GHR_BITS   = PREDICTOR_GHR_BITS,
  parameter int CNT_BITS   = 2,
  parameter int USE_GSHARE = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                fetch_valid_in,
  input  logic [31:0]         pc_from_fetcher,
  input  logic [31:0]         inst_from_fetcher,
  output logic [31:0]         imm_to_fetcher,
  output logic                jump_predict_flag_to_fetcher,
  output logic                is_jalr_inst_to_fetcher,
  output logic [GHR_BITS-1:0] ghr_to_fetcher,
  input  logic                enable_from_reorderbuffer,
  input  logic [31:0]         inst_addr_from_reorderbuffer,
  input  logic                jump_result_from_reorderbuffer,
  input  logic [GHR_BITS-1:0] ghr_from_reorderbuffer,
  input  logic                mispredict_from_reorderbuffer
`ifdef GSHARE_PREDICTOR_STATS_EN
  ,
  output logic [31:0]         stat_branch_cnt_out,
  output logic [31:0]         stat_mispredict_cnt_out
`endif
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

  function automatic logic [INDEX_BITS-1:0] table_idx(input logic [INDEX_BITS-1:0] word,
                                                      input logic [GHR_BITS-1:0]   hist);
    if (USE_GSHARE != 0) return word ^ INDEX_BITS'(hist);
    return word;
  endfunction

  logic [CNT_BITS-1:0]   r_cnt [DEPTH];
  logic [GHR_BITS-1:0]   r_ghr;

  inst_t                 w_inst;
  logic [6:0]            w_opcode;
  logic                  w_is_branch;
  logic                  w_is_jal;
  logic [INDEX_BITS-1:0] w_fetch_idx;
  logic [INDEX_BITS-1:0] w_commit_idx;
  logic [CNT_BITS-1:0]   w_fetch_cnt;
  logic [CNT_BITS-1:0]   w_cnt_next;
  logic                  w_flush;
  data_t                 w_imm_j;
  data_t                 w_imm_b;
  logic                  w_unused;

  assign w_inst      = inst_from_fetcher;
  assign w_opcode    = w_inst[OPCODE_RANGE_HI:OPCODE_RANGE_LO];
  assign w_is_branch = (w_opcode == OPCODE_BRANCH);
  assign w_is_jal    = (w_opcode == OPCODE_JAL);

  assign w_imm_j = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_imm_b = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};

  assign w_fetch_idx  = table_idx(pc_from_fetcher[INDEX_BITS+1:2], r_ghr);
  assign w_commit_idx = table_idx(inst_addr_from_reorderbuffer[INDEX_BITS+1:2], ghr_from_reorderbuffer);
  assign w_fetch_cnt  = r_cnt[w_fetch_idx];
  assign w_flush      = enable_from_reorderbuffer & mispredict_from_reorderbuffer;

  assign imm_to_fetcher               = w_is_jal ? w_imm_j : w_imm_b;
  assign jump_predict_flag_to_fetcher = w_is_jal ? TRUE : (w_is_branch ? w_fetch_cnt[CNT_BITS-1] : FALSE);
  assign is_jalr_inst_to_fetcher      = (w_opcode == OPCODE_JALR);
  assign ghr_to_fetcher               = r_ghr;

  // Only the word-index bits of either PC select a table entry.
  assign w_unused = ^{pc_from_fetcher[31:INDEX_BITS+2], pc_from_fetcher[1:0],
                      inst_addr_from_reorderbuffer[31:INDEX_BITS+2], inst_addr_from_reorderbuffer[1:0]};

  sat_counter_update #(
    .CNT_BITS (CNT_BITS)
  ) u_sat (
    .i_val (r_cnt[w_commit_idx]),
    .i_inc (jump_result_from_reorderbuffer),
    .o_val (w_cnt_next)
  );

  // A mispredict repair always wins over the same-cycle speculative shift.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < DEPTH; k++) r_cnt[k] <= CNT_INIT;
      r_ghr <= '0;
    end else if (rdy_in) begin
      if (enable_from_reorderbuffer) r_cnt[w_commit_idx] <= w_cnt_next;
      if (w_flush) begin
        r_ghr <= GHR_BITS'({ghr_from_reorderbuffer, jump_result_from_reorderbuffer});
      end else if (fetch_valid_in && w_is_branch) begin
        r_ghr <= GHR_BITS'({r_ghr, jump_predict_flag_to_fetcher});
      end
    end
  end

`ifdef GSHARE_PREDICTOR_STATS_EN
  logic [31:0] r_stat_branch;
  logic [31:0] r_stat_mispredict;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_stat_branch     <= '0;
      r_stat_mispredict <= '0;
    end else if (rdy_in && enable_from_reorderbuffer) begin
      r_stat_branch <= r_stat_branch + 32'd1;
      if (mispredict_from_reorderbuffer) r_stat_mispredict <= r_stat_mispredict + 32'd1;
    end
  end

  assign stat_branch_cnt_out     = r_stat_branch;
  assign stat_mispredict_cnt_out = r_stat_mispredict;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed scenarios with literal expectations plus randomized traffic against a table/history model.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Stats outputs are checked when GSHARE_PREDICTOR_STATS_EN is defined.
module tb_gshare_predictor;

  localparam logic [31:0] INST_BR   = 32'h0000_0063;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [31:0] INST_JALM4 = 32'hFFDF_F06F;
  localparam logic [31:0] INST_RET  = 32'h0000_8067;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, fetch_valid_in;
  logic [31:0] pc_from_fetcher, inst_from_fetcher, imm_to_fetcher;
  logic        jump_predict_flag_to_fetcher, is_jalr_inst_to_fetcher;
  logic [7:0]  ghr_to_fetcher, ghr_from_reorderbuffer;
  logic        enable_from_reorderbuffer, jump_result_from_reorderbuffer, mispredict_from_reorderbuffer;
  logic [31:0] inst_addr_from_reorderbuffer;
`ifdef GSHARE_PREDICTOR_STATS_EN
  logic [31:0] stat_branch_cnt_out, stat_mispredict_cnt_out;
`endif

  always #5 clk_in = ~clk_in;

  gshare_predictor #(
    .INDEX_BITS (9), .GHR_BITS (8), .CNT_BITS (2), .USE_GSHARE (1)
  ) dut (
    .clk_in                         (clk_in),
    .rst_in                         (rst_in),
    .rdy_in                         (rdy_in),
    .fetch_valid_in                 (fetch_valid_in),
    .pc_from_fetcher                (pc_from_fetcher),
    .inst_from_fetcher              (inst_from_fetcher),
    .imm_to_fetcher                 (imm_to_fetcher),
    .jump_predict_flag_to_fetcher   (jump_predict_flag_to_fetcher),
    .is_jalr_inst_to_fetcher        (is_jalr_inst_to_fetcher),
    .ghr_to_fetcher                 (ghr_to_fetcher),
    .enable_from_reorderbuffer      (enable_from_reorderbuffer),
    .inst_addr_from_reorderbuffer   (inst_addr_from_reorderbuffer),
    .jump_result_from_reorderbuffer (jump_result_from_reorderbuffer),
    .ghr_from_reorderbuffer         (ghr_from_reorderbuffer),
    .mispredict_from_reorderbuffer  (mispredict_from_reorderbuffer)
`ifdef GSHARE_PREDICTOR_STATS_EN
    ,
    .stat_branch_cnt_out            (stat_branch_cnt_out),
    .stat_mispredict_cnt_out        (stat_mispredict_cnt_out)
`endif
  );

  // Reference model: 512 counters in 0..3, history as a plain integer.
  int          model_cnt [512];
  int          model_ghr;
  int unsigned model_bcnt, model_mcnt;
  bit          model_valid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  bit          lit_pred_en = 0, lit_ghr_en = 0, lit_imm_en = 0, lit_jalr_en = 0, lit_stat_en = 0;
  logic [31:0] lit_pred, lit_ghr, lit_imm, lit_jalr, lit_bcnt, lit_mcnt;

  function automatic int mdl_idx(logic [31:0] pc, int h);
    return int'(((pc >> 2) ^ 32'(h)) & 32'h1FF);
  endfunction

  function automatic bit mdl_pred(logic [31:0] pc, logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    if (op == 7'h6F) return 1'b1;
    if (op == 7'h63) return model_cnt[mdl_idx(pc, model_ghr)] >= 2;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_imm(logic [31:0] inst);
    logic [20:0] j;
    logic [12:0] b;
    j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    if (inst[6:0] == 7'h6F) return 32'($signed(j));
    return 32'($signed(b));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk_in) begin
    bit p;
    int j;
    if (rst_in) begin
      for (int k = 0; k < 512; k++) model_cnt[k] = 1;
      model_ghr   = 0;
      model_bcnt  = 0;
      model_mcnt  = 0;
      model_valid = 1'b1;
    end else if (rdy_in && model_valid) begin
      p = mdl_pred(pc_from_fetcher, inst_from_fetcher);
      if (enable_from_reorderbuffer) begin
        j = mdl_idx(inst_addr_from_reorderbuffer, int'(ghr_from_reorderbuffer));
        if (jump_result_from_reorderbuffer) model_cnt[j] = (model_cnt[j] == 3) ? 3 : model_cnt[j] + 1;
        else                                model_cnt[j] = (model_cnt[j] == 0) ? 0 : model_cnt[j] - 1;
        model_bcnt++;
        if (mispredict_from_reorderbuffer) model_mcnt++;
      end
      if (enable_from_reorderbuffer && mispredict_from_reorderbuffer)
        model_ghr = ((int'(ghr_from_reorderbuffer) * 2) + int'(jump_result_from_reorderbuffer)) % 256;
      else if (fetch_valid_in && inst_from_fetcher[6:0] == 7'h63)
        model_ghr = ((model_ghr * 2) + int'(p)) % 256;
    end
  end

  always @(negedge clk_in) begin
    if (model_valid) begin
      check("pred", 32'(jump_predict_flag_to_fetcher), 32'(mdl_pred(pc_from_fetcher, inst_from_fetcher)));
      check("imm", imm_to_fetcher, mdl_imm(inst_from_fetcher));
      check("jalr", 32'(is_jalr_inst_to_fetcher), 32'(inst_from_fetcher[6:0] == 7'h67));
      check("ghr", 32'(ghr_to_fetcher), 32'(model_ghr));
`ifdef GSHARE_PREDICTOR_STATS_EN
      check("stat_branch", stat_branch_cnt_out, model_bcnt);
      check("stat_mispredict", stat_mispredict_cnt_out, model_mcnt);
`endif
    end
    if (lit_pred_en) check("lit_pred", 32'(jump_predict_flag_to_fetcher), lit_pred);
    if (lit_ghr_en)  check("lit_ghr", 32'(ghr_to_fetcher), lit_ghr);
    if (lit_imm_en)  check("lit_imm", imm_to_fetcher, lit_imm);
    if (lit_jalr_en) check("lit_jalr", 32'(is_jalr_inst_to_fetcher), lit_jalr);
`ifdef GSHARE_PREDICTOR_STATS_EN
    if (lit_stat_en) begin
      check("lit_stat_branch", stat_branch_cnt_out, lit_bcnt);
      check("lit_stat_mispredict", stat_mispredict_cnt_out, lit_mcnt);
    end
`endif
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    lit_pred_en = 0; lit_ghr_en = 0; lit_imm_en = 0; lit_jalr_en = 0; lit_stat_en = 0;
  endtask

  task automatic fetch(logic v, logic [31:0] pc, logic [31:0] inst);
    fetch_valid_in = v; pc_from_fetcher = pc; inst_from_fetcher = inst;
  endtask

  task automatic commit(logic en, logic [31:0] addr, logic res, logic [7:0] snap, logic mis);
    enable_from_reorderbuffer = en; inst_addr_from_reorderbuffer = addr;
    jump_result_from_reorderbuffer = res; ghr_from_reorderbuffer = snap;
    mispredict_from_reorderbuffer = mis;
  endtask

  task automatic expect_pg(int p, int g);
    if (p >= 0) begin lit_pred_en = 1; lit_pred = 32'(p); end
    if (g >= 0) begin lit_ghr_en = 1; lit_ghr = 32'(g); end
  endtask

  initial begin
    rst_in = 1; rdy_in = 1;
    fetch(0, 32'h0, INST_NOP);
    commit(0, 32'h0, 0, 8'h00, 0);
    tick(); tick();
    rst_in = 0;

    // Fresh table: weakly not taken, empty history.
    fetch(1, 32'h100, INST_BR); expect_pg(0, 0); tick();

    // Train entry for pc 0x100 / history 0.
    fetch(0, 32'h100, INST_BR);
    commit(1, 32'h100, 1, 8'h00, 0); tick(); tick();
    commit(0, 32'h100, 0, 8'h00, 0); expect_pg(1, 0); tick();
    commit(1, 32'h100, 1, 8'h00, 0); tick(); tick(); tick();
    commit(1, 32'h100, 0, 8'h00, 0); tick();
    commit(0, 32'h100, 0, 8'h00, 0); expect_pg(1, 0); tick();
    commit(1, 32'h100, 0, 8'h00, 0); tick();
    commit(0, 32'h100, 0, 8'h00, 0); expect_pg(0, 0); tick();

    // Three not-taken fetches, then repair from snapshot 0x05 with a taken outcome.
    fetch(1, 32'h200, INST_BR); expect_pg(0, 0); tick();
    fetch(1, 32'h204, INST_BR); expect_pg(0, 0); tick();
    fetch(1, 32'h208, INST_BR); expect_pg(0, 0); tick();
    fetch(0, 32'h208, INST_BR);
    commit(1, 32'h200, 1, 8'h05, 1); tick();
    commit(0, 32'h200, 0, 8'h00, 0); expect_pg(-1, 8'h0B); tick();

    // Repair in the same cycle as a fetch shift: repair wins.
    fetch(1, 32'h300, INST_BR); commit(1, 32'h300, 0, 8'h00, 1); expect_pg(-1, 8'h0B); tick();
    fetch(0, 32'h300, INST_BR); commit(0, 32'h300, 0, 8'h00, 0); expect_pg(-1, 0); tick();

    // JAL -4 and JALR: no history shift.
    fetch(1, 32'h400, INST_JALM4); expect_pg(1, 0);
    lit_imm_en = 1; lit_imm = 32'hFFFF_FFFC; lit_jalr_en = 1; lit_jalr = 0; tick();
    fetch(1, 32'h404, INST_RET); expect_pg(0, 0); lit_jalr_en = 1; lit_jalr = 1; tick();
    fetch(0, 32'h404, INST_NOP); expect_pg(0, 0); tick();

    // Stall: commits and fetches leave everything untouched.
    rdy_in = 0;
    fetch(1, 32'h200, INST_BR); commit(1, 32'h200, 1, 8'h00, 0); tick();
    commit(1, 32'h200, 1, 8'hFF, 1); tick();
    rdy_in = 1;
    fetch(0, 32'h200, INST_BR); commit(0, 32'h200, 0, 8'h00, 0); expect_pg(0, 0); tick();

    // Mid-stream reset, then 3 commits with 1 mispredict and a stalled commit.
    rst_in = 1; tick(); rst_in = 0;
    commit(1, 32'h500, 1, 8'h00, 0); tick();
    commit(1, 32'h500, 1, 8'h00, 1); tick();
    commit(1, 32'h504, 0, 8'h00, 0); tick();
    rdy_in = 0; commit(1, 32'h504, 0, 8'h00, 1); tick();
    rdy_in = 1; commit(0, 32'h0, 0, 8'h00, 0);
    lit_stat_en = 1; lit_bcnt = 3; lit_mcnt = 1; expect_pg(-1, 1); tick();

    // Randomized traffic with a small address footprint to force aliasing.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 4))
        0, 1: ins[6:0] = 7'h63;
        2:    ins[6:0] = 7'h6F;
        3:    ins[6:0] = 7'h67;
        default: ;
      endcase
      rst_in = ($urandom_range(0, 299) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      fetch(1'($urandom), $urandom & 32'h0000_F03C, ins);
      commit(1'($urandom), $urandom & 32'h0000_F03C, 1'($urandom),
             8'($urandom & 32'h0F), ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
